// File: rtl/tick_scheduler_pkg.sv
// ============================================================================
//  Module      : tick_scheduler_pkg
//  Description : Shared constants, FSM encoding and helpers for the tick
//                scheduler (timing controller and frame-update sequencer).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tick_scheduler_pkg;

    // Default divider exponents: enable period is 2^N master-clock cycles
    localparam int c_PIX_DIV_LOG2    = 1;        // 25 MHz pixel enable
    localparam int c_SEG_DIV_LOG2    = 17;       // ~381 Hz segment scan
    localparam int c_RENDER_DIV_LOG2 = 20;       // ~47.7 Hz render tick

    // Longest time update_req may stay high without an acknowledge
    localparam int c_TIMEOUT_CYC     = 1000000;

    // Datapath widths
    localparam int c_CNT_W   = 32;
    localparam int c_FRAME_W = 16;
    localparam int c_OVR_W   = 8;
    localparam int c_DIGIT_W = 2;

    // Handshake FSM encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } hs_state_t;

    // Increment that sticks at the all-ones value instead of wrapping
    function automatic logic [c_OVR_W-1:0] sat_inc(input logic [c_OVR_W-1:0] v);
        return (&v) ? v : v + c_OVR_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_scheduler_if.sv
// ============================================================================
//  Module      : tick_scheduler_if
//  Description : Frame-update handshake and status bundle between the tick
//                scheduler (master) and the game/physics logic (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tick_scheduler_if;
    import tick_scheduler_pkg::*;

    logic                 update_req;
    logic                 update_ack;
    logic [c_FRAME_W-1:0] frame_cnt;
    logic [c_OVR_W-1:0]   overrun_cnt;
    logic                 timeout_flag;

    modport master (
        output update_req,
        output frame_cnt,
        output overrun_cnt,
        output timeout_flag,
        input  update_ack
    );

    modport slave (
        input  update_req,
        input  frame_cnt,
        input  overrun_cnt,
        input  timeout_flag,
        output update_ack
    );

endinterface

`default_nettype wire

// File: rtl/tick_scheduler_frame_handshake.sv
// ============================================================================
//  Module      : frame_handshake
//  Description : Per-frame req/ack sequencer. Raises update_req on a render
//                tick, waits for update_ack or a timeout, counts completed
//                frames, dropped ticks (overruns) and flags timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_handshake
    import tick_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC    // must be >= 2
) (
    input  wire logic                 clk,
    input  wire logic                 clr,
    input  wire logic                 i_render_tick,
    input  wire logic                 i_update_ack,
    output logic                      o_update_req,
    output logic [c_FRAME_W-1:0]      o_frame_cnt,
    output logic [c_OVR_W-1:0]        o_overrun_cnt,
    output logic                      o_timeout_flag
);

    // Wait counter only needs to reach TIMEOUT_CYC-1
    localparam int                c_WAIT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYC - 1);

    hs_state_t            r_state,   w_state_nxt;
    logic [c_WAIT_W-1:0]  r_wait,    w_wait_nxt;
    logic                 r_req,     w_req_nxt;
    logic [c_FRAME_W-1:0] r_frame,   w_frame_nxt;
    logic [c_OVR_W-1:0]   r_ovr,     w_ovr_nxt;
    logic                 r_tout,    w_tout_nxt;

    // State register: everything returns to reset on the clr edge
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
            r_req   <= 1'b0;
            r_frame <= '0;
            r_ovr   <= '0;
            r_tout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_req   <= w_req_nxt;
            r_frame <= w_frame_nxt;
            r_ovr   <= w_ovr_nxt;
            r_tout  <= w_tout_nxt;
        end
    end

    // Next-state logic: start on a tick, finish on ack or timeout, drop busy ticks
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_req_nxt   = r_req;
        w_frame_nxt = r_frame;
        w_ovr_nxt   = r_ovr;
        w_tout_nxt  = r_tout;

        case (r_state)
            ST_IDLE: begin
                // An acknowledge arriving while idle has no effect
                if (i_render_tick) begin
                    w_req_nxt   = 1'b1;
                    w_wait_nxt  = '0;
                    w_state_nxt = ST_BUSY;
                end
            end

            ST_BUSY: begin
                w_wait_nxt = r_wait + c_WAIT_W'(1);

                // Ticks are never queued; a tick seen while busy is lost,
                // even in the cycle the handshake completes
                if (i_render_tick) begin
                    w_ovr_nxt = sat_inc(r_ovr);
                end

                if (i_update_ack) begin
                    w_req_nxt   = 1'b0;
                    w_frame_nxt = r_frame + c_FRAME_W'(1);
                    w_state_nxt = ST_IDLE;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_req_nxt   = 1'b0;
                    w_tout_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_update_req   = r_req;
    assign o_frame_cnt    = r_frame;
    assign o_overrun_cnt  = r_ovr;
    assign o_timeout_flag = r_tout;

endmodule

`default_nettype wire

// File: rtl/tick_scheduler.sv
// ============================================================================
//  Module      : tick_scheduler
//  Description : Central timing controller. One free-running 32-bit divider
//                drives single-cycle clock-enable strobes for the pixel,
//                7-seg scan and render domains, and render ticks start the
//                per-frame update handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int PIX_DIV_LOG2    = c_PIX_DIV_LOG2,     // >= 1
    parameter int SEG_DIV_LOG2    = c_SEG_DIV_LOG2,     // >= 1
    parameter int RENDER_DIV_LOG2 = c_RENDER_DIV_LOG2,  // >= 1 and < 32
    parameter int TIMEOUT_CYC     = c_TIMEOUT_CYC       // >= 2
) (
    input  wire logic                 clk,
    input  wire logic                 clr,
    input  wire logic                 run,
    output logic                      pix_ce,
    output logic                      seg_ce,
    output logic [c_DIGIT_W-1:0]      seg_digit,
    output logic                      render_tick,
    tick_scheduler_if.master          hs
);

    logic [c_CNT_W-1:0]   r_q;
    logic [c_DIGIT_W-1:0] r_seg_digit;
    logic                 w_pix_ce;
    logic                 w_seg_ce;
    logic                 w_render_tick;
    logic                 w_q_unused;

    // Free-running divider; keeps counting while the game is paused
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else begin
            r_q <= r_q + c_CNT_W'(1);
        end
    end

    // Each strobe fires when the low N counter bits are all ones, so all are
    // quiet at q=0 and the first pixel enable lands at q=1
    assign w_pix_ce      = &r_q[PIX_DIV_LOG2-1:0];
    assign w_seg_ce      = &r_q[SEG_DIV_LOG2-1:0];
    assign w_render_tick = run & (&r_q[RENDER_DIV_LOG2-1:0]);

    // Upper divider bits are not decoded by every configuration
    assign w_q_unused    = ^r_q;

    // Active 7-seg digit advances the cycle after each scan enable
    always_ff @(posedge clk) begin
        if (clr) begin
            r_seg_digit <= '0;
        end else if (w_seg_ce) begin
            r_seg_digit <= r_seg_digit + c_DIGIT_W'(1);
        end
    end

    frame_handshake #(
        .TIMEOUT_CYC    (TIMEOUT_CYC)
    ) u_frame_handshake (
        .clk            (clk),
        .clr            (clr),
        .i_render_tick  (w_render_tick),
        .i_update_ack   (hs.update_ack),
        .o_update_req   (hs.update_req),
        .o_frame_cnt    (hs.frame_cnt),
        .o_overrun_cnt  (hs.overrun_cnt),
        .o_timeout_flag (hs.timeout_flag)
    );

    assign pix_ce      = w_pix_ce;
    assign seg_ce      = w_seg_ce;
    assign seg_digit   = r_seg_digit;
    assign render_tick = w_render_tick;

endmodule

`default_nettype wire

// File: tb/tb_tick_scheduler.sv
// ============================================================================
//  Module      : tb_tick_scheduler
//  Description : Self-checking bench for tick_scheduler. Two instances share
//                clock, clr and run: A with a short timeout, B with a long
//                timeout so handshakes can span several render ticks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_scheduler;

    localparam int PIX   = 1;
    localparam int SEG   = 3;
    localparam int REND  = 5;
    localparam int TMO_A = 8;
    localparam int TMO_B = 128;

    logic       clk = 1'b0;
    logic       clr;
    logic       run;
    logic       acka;
    logic       ackb;

    logic       pix_a, seg_a, rt_a, pix_b, seg_b, rt_b;
    logic [1:0] dig_a, dig_b;

    tick_scheduler_if ifa ();
    tick_scheduler_if ifb ();

    assign ifa.update_ack = acka;
    assign ifb.update_ack = ackb;

    tick_scheduler #(
        .PIX_DIV_LOG2(PIX), .SEG_DIV_LOG2(SEG), .RENDER_DIV_LOG2(REND), .TIMEOUT_CYC(TMO_A)
    ) dut_a (
        .clk(clk), .clr(clr), .run(run), .pix_ce(pix_a), .seg_ce(seg_a),
        .seg_digit(dig_a), .render_tick(rt_a), .hs(ifa)
    );

    tick_scheduler #(
        .PIX_DIV_LOG2(PIX), .SEG_DIV_LOG2(SEG), .RENDER_DIV_LOG2(REND), .TIMEOUT_CYC(TMO_B)
    ) dut_b (
        .clk(clk), .clr(clr), .run(run), .pix_ce(pix_b), .seg_ce(seg_b),
        .seg_digit(dig_b), .render_tick(rt_b), .hs(ifb)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: cycle count since clr, scan pulses seen, and per
    // instance the outstanding request with its age in cycles
    int unsigned mq;
    int          mdig;
    bit          mbusy [2];
    int          mage  [2];
    int          mfc   [2];
    int          moc   [2];
    bit          mto   [2];
    int          tmo   [2] = '{TMO_A, TMO_B};

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (model q=%0d, t=%0t)", name, act, exp, mq, $time);
        end
    endtask

    function automatic bit is_pix(input int unsigned q);
        return (q % (1 << PIX)) == (1 << PIX) - 1;
    endfunction
    function automatic bit is_seg(input int unsigned q);
        return (q % (1 << SEG)) == (1 << SEG) - 1;
    endfunction
    function automatic bit is_rend(input int unsigned q);
        return (q % (1 << REND)) == (1 << REND) - 1;
    endfunction

    task automatic model_update();
        bit ack [2];
        bit tick;
        ack[0] = acka;
        ack[1] = ackb;
        if (clr) begin
            mq = 0;
            mdig = 0;
            for (int k = 0; k < 2; k++) begin
                mbusy[k] = 0; mage[k] = 0; mfc[k] = 0; moc[k] = 0; mto[k] = 0;
            end
        end else begin
            tick = run && is_rend(mq);
            for (int k = 0; k < 2; k++) begin
                if (!mbusy[k]) begin
                    if (tick) begin
                        mbusy[k] = 1;
                        mage[k] = 0;
                    end
                end else begin
                    mage[k]++;
                    if (tick && moc[k] < 255) moc[k]++;
                    if (ack[k]) begin
                        mbusy[k] = 0;
                        mfc[k] = (mfc[k] + 1) % 65536;
                    end else if (mage[k] == tmo[k]) begin
                        mbusy[k] = 0;
                        mto[k] = 1;
                    end
                end
            end
            if (is_seg(mq)) mdig = (mdig + 1) % 4;
            mq++;
        end
    endtask

    task automatic check_all();
        bit ert;
        ert = run && is_rend(mq);
        chk("pix_a", pix_a, is_pix(mq));  chk("pix_b", pix_b, is_pix(mq));
        chk("seg_a", seg_a, is_seg(mq));  chk("seg_b", seg_b, is_seg(mq));
        chk("dig_a", dig_a, mdig);        chk("dig_b", dig_b, mdig);
        chk("rt_a", rt_a, ert);           chk("rt_b", rt_b, ert);
        chk("req_a", ifa.update_req, mbusy[0]);   chk("req_b", ifb.update_req, mbusy[1]);
        chk("fcnt_a", ifa.frame_cnt, mfc[0]);     chk("fcnt_b", ifb.frame_cnt, mfc[1]);
        chk("ocnt_a", ifa.overrun_cnt, moc[0]);   chk("ocnt_b", ifb.overrun_cnt, moc[1]);
        chk("tflag_a", ifa.timeout_flag, mto[0]); chk("tflag_b", ifb.timeout_flag, mto[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic run_to(input int unsigned q);
        int guard = 0;
        while (mq != q && guard < 2000) begin
            step();
            guard++;
        end
        chk("run_to_reached", mq, q);
    endtask

    typedef struct {
        int unsigned q;
        bit          ack;
        bit          pix;
        bit          seg;
        int          dig;
        bit          rt;
        bit          req;
        int          fcnt;
        bit          tflag;
    } vec_t;

    vec_t vecs [$];

    // Hard watchdog in case a wait inside the simulator itself stalls
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int npix, nseg, guard;

        // Hand-derived checkpoints for instance A after clr, run held high:
        //             q  ack pix seg dig rt req fcnt tflag
        vecs.push_back('{ 1, 0, 1, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{ 2, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{ 7, 0, 1, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{ 8, 0, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{16, 0, 0, 0, 2, 0, 0, 0, 0});
        vecs.push_back('{23, 0, 1, 1, 2, 0, 0, 0, 0});
        vecs.push_back('{24, 0, 0, 0, 3, 0, 0, 0, 0});
        vecs.push_back('{31, 0, 1, 1, 3, 1, 0, 0, 0});
        vecs.push_back('{32, 0, 0, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{35, 1, 1, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{36, 0, 0, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{63, 0, 1, 1, 3, 1, 0, 1, 0});
        vecs.push_back('{64, 0, 0, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{71, 0, 1, 1, 0, 0, 1, 1, 0});
        vecs.push_back('{72, 0, 0, 0, 1, 0, 0, 1, 1});
        vecs.push_back('{95, 0, 1, 1, 3, 1, 0, 1, 1});
        vecs.push_back('{96, 1, 0, 0, 0, 0, 1, 1, 1});
        vecs.push_back('{97, 0, 1, 0, 0, 0, 0, 2, 1});

        clr = 1'b1; run = 1'b0; acka = 1'b0; ackb = 1'b0;
        mq = 0;
        mdig = 0;
        for (int k = 0; k < 2; k++) begin
            mbusy[k] = 0; mage[k] = 0; mfc[k] = 0; moc[k] = 0; mto[k] = 0;
        end
        step();
        step();
        clr = 1'b0;
        run = 1'b1;

        // Table-driven: enable decode, digit, one acked and one timed-out frame
        foreach (vecs[i]) begin
            run_to(vecs[i].q);
            chk("vec_pix",   pix_a, vecs[i].pix);
            chk("vec_seg",   seg_a, vecs[i].seg);
            chk("vec_dig",   dig_a, vecs[i].dig);
            chk("vec_rt",    rt_a,  vecs[i].rt);
            chk("vec_req",   ifa.update_req, vecs[i].req);
            chk("vec_fcnt",  ifa.frame_cnt, vecs[i].fcnt);
            chk("vec_tflag", ifa.timeout_flag, vecs[i].tflag);
            acka = vecs[i].ack;
            step();
            acka = 1'b0;
        end

        // Paused game: strobes keep running, no ticks and no new requests
        run = 1'b0;
        npix = 0;
        nseg = 0;
        for (int i = 0; i < 128; i++) begin
            step();
            npix += int'(pix_a);
            nseg += int'(seg_a);
            chk("pause_rt", rt_a, 0);
            chk("pause_req", ifa.update_req, 0);
        end
        chk("pause_pix_pulses", npix, 64);
        chk("pause_seg_pulses", nseg, 16);

        // Drop run mid-handshake; the pending update still completes
        run = 1'b1;
        guard = 0;
        while (ifa.update_req !== 1'b1 && guard < 64) begin
            step();
            guard++;
        end
        chk("resume_req_rise", ifa.update_req, 1);
        run = 1'b0;
        step();
        step();
        acka = 1'b1;
        step();
        acka = 1'b0;
        chk("norun_ack_req", ifa.update_req, 0);
        chk("norun_ack_fcnt", ifa.frame_cnt, 3);

        // Overruns across ticks on B, then ack coinciding with a tick
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_pix", pix_a, 0);
        chk("clr_fcnt_a", ifa.frame_cnt, 0);
        run = 1'b1;
        run_to(127);
        chk("ovr_req_b", ifb.update_req, 1);
        chk("ovr_before_ack", ifb.overrun_cnt, 2);
        chk("ovr_tick_b", rt_b, 1);
        chk("ovr_tflag_b", ifb.timeout_flag, 0);
        ackb = 1'b1;
        step();
        ackb = 1'b0;
        chk("ovr_after_req", ifb.update_req, 0);
        chk("ovr_after_cnt", ifb.overrun_cnt, 3);
        chk("ovr_after_fcnt", ifb.frame_cnt, 1);

        // clr while B is busy with two overruns and A has timed out
        clr = 1'b1;
        step();
        clr = 1'b0;
        run_to(100);
        chk("mid_req_b", ifb.update_req, 1);
        chk("mid_ocnt_b", ifb.overrun_cnt, 2);
        chk("mid_tflag_a", ifa.timeout_flag, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("rst_req_b", ifb.update_req, 0);
        chk("rst_ocnt_b", ifb.overrun_cnt, 0);
        chk("rst_tflag_a", ifa.timeout_flag, 0);
        chk("rst_dig", dig_b, 0);
        chk("rst_pix", pix_b, 0);
        step();
        chk("rst_first_pix", pix_b, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            clr  = ($urandom % 600) == 0;
            run  = ($urandom % 8) != 0;
            acka = ($urandom % 5) == 0;
            ackb = ($urandom % 24) == 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
